// File: rtl/vga_bounce_renderer.sv
// Draws NUM_RECTS bouncing solid rectangles over a background colour.
// Two-stage colour pipeline; sync/blank are delayed to stay aligned with colour.
module vga_bounce_renderer #(
  parameter int ACTIVE_H  = 640,
  parameter int ACTIVE_V  = 480,
  parameter int NUM_RECTS = 2,
  parameter int RECT_W    = 100,
  parameter int RECT_H    = 100,
  parameter int SPEED     = 2,
  parameter logic [11*NUM_RECTS-1:0] START_X = {11'd400, 11'd100},
  parameter logic [11*NUM_RECTS-1:0] START_Y = {11'd300, 11'd100},
  parameter logic [24*NUM_RECTS-1:0] COLOURS = {24'h00FF00, 24'hFF0000},
  parameter logic [23:0] BG_COLOUR = 24'h0000FF
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        blank_n_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [10:0] pixel_h,
  input  logic [10:0] pixel_v,
  output logic        blank_n,
  output logic        HS,
  output logic        VS,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic [11:0] LIM_X = 12'(ACTIVE_H - RECT_W);
  localparam logic [11:0] LIM_Y = 12'(ACTIVE_V - RECT_H);
  localparam logic [11:0] RW    = 12'(RECT_W);
  localparam logic [11:0] RH    = 12'(RECT_H);
  localparam logic [11:0] SPD   = 12'(SPEED);

  logic [NUM_RECTS-1:0][10:0] pos_x, pos_y;
  logic [NUM_RECTS-1:0]       dir_x, dir_y;   // 1 = moving towards 0
  logic [NUM_RECTS-1:0]       hit_c, hit_s1;
  logic                       blank_s1, hs_s1, vs_s1;
  logic [10:0]                pixel_v_d;
  logic                       tick;
  logic [23:0]                colour_c;

  // Returns {new_dir, new_pos}; 12-bit maths so pos+SPEED cannot wrap.
  function automatic logic [11:0] step_axis(input logic [10:0] p, input logic neg,
                                            input logic [11:0] lim);
    logic [11:0] p12;
    p12 = {1'b0, p};
    if (!neg) begin
      if (p12 + SPD >= lim) return {1'b1, lim[10:0]};
      else                  return {1'b0, 11'(p12 + SPD)};
    end else begin
      if (p12 <= SPD) return {1'b0, 11'd0};
      else            return {1'b1, 11'(p12 - SPD)};
    end
  endfunction

  assign tick = (pixel_v_d == 11'(ACTIVE_V - 1)) && (pixel_v == 11'(ACTIVE_V));

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_c[i] = ({1'b0, pixel_h} >= {1'b0, pos_x[i]}) &&
                 ({1'b0, pixel_h} <  {1'b0, pos_x[i]} + RW) &&
                 ({1'b0, pixel_v} >= {1'b0, pos_y[i]}) &&
                 ({1'b0, pixel_v} <  {1'b0, pos_y[i]} + RH);
    end
  end

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    colour_c = BG_COLOUR;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_s1[i]) colour_c = COLOURS[24*i +: 24];
    end
    if (!blank_s1) colour_c = 24'h000000;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hit_s1    <= '0;
      blank_s1  <= 1'b0;
      hs_s1     <= 1'b1;
      vs_s1     <= 1'b1;
      blank_n   <= 1'b0;
      HS        <= 1'b1;
      VS        <= 1'b1;
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      pixel_v_d <= '0;
    end else begin
      hit_s1    <= hit_c;
      blank_s1  <= blank_n_in;
      hs_s1     <= hs_in;
      vs_s1     <= vs_in;
      blank_n   <= blank_s1;
      HS        <= hs_s1;
      VS        <= vs_s1;
      red       <= colour_c[23:16];
      green     <= colour_c[15:8];
      blue      <= colour_c[7:0];
      pixel_v_d <= pixel_v;
    end
  end

  // Positions only change on the vertical-blank tick, so frames never tear.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        pos_x[i] <= START_X[11*i +: 11];
        pos_y[i] <= START_Y[11*i +: 11];
        dir_x[i] <= (i % 2 == 1);
        dir_y[i] <= 1'b0;
      end
    end else if (tick && enable) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        {dir_x[i], pos_x[i]} <= step_axis(pos_x[i], dir_x[i], LIM_X);
        {dir_y[i], pos_y[i]} <= step_axis(pos_y[i], dir_y[i], LIM_Y);
      end
    end
  end

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Directed bench for vga_bounce_renderer: colour lookup, sync delay, bounce motion, reset.
module tb_vga_bounce_renderer;
  logic        vga_clk = 1'b0;
  logic        reset, enable, en2, blank_n_in, hs_in, vs_in;
  logic [10:0] pixel_h, pixel_v;
  logic        blank_n, HS, VS;
  logic [7:0]  red, green, blue;
  logic        blank_n2, HS2, VS2;
  logic [7:0]  red2, green2, blue2;
  int          errors = 0;
  int          checks = 0;
  logic [2:0]  pat [0:9];

  always #5 vga_clk = ~vga_clk;

  vga_bounce_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .enable(enable), .blank_n_in(blank_n_in),
    .hs_in(hs_in), .vs_in(vs_in), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .blank_n(blank_n), .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue));

  vga_bounce_renderer #(
    .START_X({11'd100, 11'd100}), .START_Y({11'd100, 11'd100})
  ) dut2 (
    .vga_clk(vga_clk), .reset(reset), .enable(en2), .blank_n_in(blank_n_in),
    .hs_in(hs_in), .vs_in(vs_in), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .blank_n(blank_n2), .HS(HS2), .VS(VS2), .red(red2), .green(green2), .blue(blue2));

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input int h, input int v, input logic bl);
    pixel_h = 11'(h); pixel_v = 11'(v); blank_n_in = bl;
    cyc(); cyc();
  endtask

  task automatic frame_tick();
    blank_n_in = 1'b0;
    pixel_v = 11'd479; cyc();
    pixel_v = 11'd480; cyc();
    pixel_v = 11'd0;   cyc();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; en2 = 1'b0; blank_n_in = 1'b1;
    hs_in = 1'b0; vs_in = 1'b0; pixel_h = '0; pixel_v = 11'd5;
    cyc(); cyc();
    check("reset_rgb", {red, green, blue}, 24'h000000);
    check("reset_sync", {blank_n, HS, VS}, 3'b011);
    reset = 1'b0; hs_in = 1'b1; vs_in = 1'b1;

    pixel(150, 150, 1'b1);
    check("rect0_hit", {red, green, blue}, 24'hFF0000);
    pixel(99, 150, 1'b1);
    check("left_of_rect0", {red, green, blue}, 24'h0000FF);
    pixel(200, 150, 1'b1);
    check("right_edge_excl", {red, green, blue}, 24'h0000FF);
    pixel(150, 150, 1'b0);
    check("blanked", {red, green, blue}, 24'h000000);
    pixel(450, 350, 1'b1);
    check("rect1_hit", {red, green, blue}, 24'h00FF00);
    pixel(499, 399, 1'b1);
    check("rect1_corner", {red, green, blue}, 24'h00FF00);

    pat[0] = 3'b111; pat[1] = 3'b010; pat[2] = 3'b101; pat[3] = 3'b000; pat[4] = 3'b110;
    pat[5] = 3'b001; pat[6] = 3'b011; pat[7] = 3'b100; pat[8] = 3'b111; pat[9] = 3'b010;
    for (int k = 0; k < 10; k++) begin
      {blank_n_in, hs_in, vs_in} = pat[k];
      cyc();
      if (k >= 1) check("sync_delay", {blank_n, HS, VS}, pat[k-1]);
    end
    hs_in = 1'b1; vs_in = 1'b1;

    for (int t = 0; t < 219; t++) frame_tick();
    check("x_after_219", dut.pos_x[0], 11'd538);
    check("dx_after_219", dut.dir_x[0], 1'b0);
    frame_tick();
    check("x_after_220", dut.pos_x[0], 11'd540);
    check("dx_after_220", dut.dir_x[0], 1'b1);
    frame_tick();
    check("x_after_221", dut.pos_x[0], 11'd538);
    check("y_after_221", dut.pos_y[0], 11'd218);
    check("r1_x_after_221", dut.pos_x[1], 11'd42);
    check("r1_y_after_221", dut.pos_y[1], 11'd18);

    enable = 1'b0;
    frame_tick();
    check("hold_x", dut.pos_x[0], 11'd538);
    check("hold_dx", dut.dir_x[0], 1'b1);
    enable = 1'b1;

    pixel(538, 218, 1'b1);
    check("moved_rect0_tl", {red, green, blue}, 24'hFF0000);
    pixel(637, 317, 1'b1);
    check("moved_rect0_br", {red, green, blue}, 24'hFF0000);
    pixel(537, 218, 1'b1);
    check("moved_rect0_left", {red, green, blue}, 24'h0000FF);
    pixel(42, 18, 1'b1);
    check("moved_rect1", {red, green, blue}, 24'h00FF00);

    pixel(150, 150, 1'b1);
    check("overlap_priority", {red2, green2, blue2}, 24'hFF0000);
    check("frozen_r0", {dut2.pos_x[0], dut2.pos_y[0]}, {11'd100, 11'd100});
    check("frozen_r1", {dut2.pos_x[1], dut2.pos_y[1]}, {11'd100, 11'd100});

    hs_in = 1'b0; vs_in = 1'b0;
    pixel(540, 220, 1'b1);
    check("pre_reset_rgb", {red, green, blue}, 24'hFF0000);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midline_reset_rgb", {red, green, blue}, 24'h000000);
    check("midline_reset_sync", {blank_n, HS, VS}, 3'b011);
    check("reset_pos", {dut.pos_x[0], dut.pos_y[0]}, {11'd100, 11'd100});
    check("reset_dir", {dut.dir_x, dut.dir_y}, 4'b1000);
    hs_in = 1'b1; vs_in = 1'b1;
    frame_tick();
    check("first_tick_after_reset", dut.pos_x[0], 11'd102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
